// File: rtl/pwm_motor_array_pkg.sv
// Shared definitions for the PWM motor array: channel state encoding and
// default parameter values.
package pwm_motor_array_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } ch_state_t;

    localparam int DEF_N_CH      = 2;
    localparam int DEF_DUTY_W    = 8;
    localparam int DEF_PRESC     = 400;
    localparam int DEF_RAMP_STEP = 4;
    localparam int DEF_FILT      = 16;
    localparam int DEF_HOLD      = 500;

endpackage

// File: rtl/pwm_motor_channel.sv
// One motor channel: duty ramp, H-bridge leg sequencing through a dead period
// on reversal, and filtered overcurrent lockout.
module pwm_motor_channel
    import pwm_motor_array_pkg::*;
#(
    parameter int DUTY_W    = DEF_DUTY_W,
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int FILT      = DEF_FILT,
    parameter int HOLD      = DEF_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_end,
    input  logic [DUTY_W-1:0] cnt,
    input  logic              enable,
    input  logic              dir,
    input  logic [DUTY_W-1:0] duty_tgt,
    input  logic              sns,
    output logic              pwm,
    output logic              fwd,
    output logic              bwd,
    output logic              fault,
    output logic [DUTY_W-1:0] duty_now
);

    localparam int FW     = $clog2(FILT + 1);
    localparam int HW     = $clog2(HOLD + 1);
    localparam int STEP_C = (RAMP_STEP > (1 << DUTY_W)) ? (1 << DUTY_W) : RAMP_STEP;
    localparam logic [DUTY_W:0] STEP = (DUTY_W + 1)'(STEP_C);

    ch_state_t         state, state_nxt;
    logic              act_dir, act_dir_nxt;
    logic [DUTY_W-1:0] duty, duty_nxt, drain_duty;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic [1:0]        sync;
    logic [FW-1:0]     filt_cnt;
    logic              filt_hit, legs_on, pwm_q;

    // Move cur toward tgt by at most STEP; computed one bit wider so it never wraps.
    function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] cur,
                                               input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] diff, step, res;
        res = {1'b0, cur};
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            step = (diff > STEP) ? STEP : diff;
            res  = {1'b0, cur} + step;
        end else if (tgt < cur) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            step = (diff > STEP) ? STEP : diff;
            res  = {1'b0, cur} - step;
        end
        return res[DUTY_W-1:0];
    endfunction

    assign filt_hit   = (filt_cnt == FW'(FILT));
    assign drain_duty = ramp(duty, '0);

    always_comb begin
        state_nxt   = state;
        act_dir_nxt = act_dir;
        duty_nxt    = duty;
        hold_nxt    = hold_cnt;
        if (filt_hit && state != ST_IDLE && state != ST_FAULT) begin
            state_nxt = ST_FAULT;
            duty_nxt  = '0;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    duty_nxt = '0;
                    if (enable) begin
                        act_dir_nxt = dir;
                        state_nxt   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable || dir != act_dir)
                        state_nxt = ST_DRAIN;
                    else if (period_end)
                        duty_nxt = ramp(duty, duty_tgt);
                end
                ST_DRAIN: begin
                    // Dead period is timed from the period_end at which duty lands on 0.
                    if (period_end) begin
                        duty_nxt = drain_duty;
                        if (drain_duty == '0)
                            state_nxt = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (period_end) begin
                        if (enable) begin
                            act_dir_nxt = dir;
                            state_nxt   = ST_RUN;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_FAULT: begin
                    duty_nxt = '0;
                    if (period_end) begin
                        if (hold_cnt == HW'(HOLD - 1)) begin
                            hold_nxt  = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            hold_nxt = hold_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign legs_on = (state == ST_RUN) || (state == ST_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            act_dir  <= 1'b0;
            duty     <= '0;
            hold_cnt <= '0;
            sync     <= '0;
            filt_cnt <= '0;
            pwm_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            act_dir  <= act_dir_nxt;
            duty     <= duty_nxt;
            hold_cnt <= hold_nxt;
            sync     <= {sync[0], sns};
            if (!sync[1])
                filt_cnt <= '0;
            else if (!filt_hit)
                filt_cnt <= filt_cnt + 1'b1;
            pwm_q    <= legs_on && (duty > cnt);
        end
    end

    assign pwm      = pwm_q;
    assign fwd      = legs_on && act_dir;
    assign bwd      = legs_on && !act_dir;
    assign fault    = (state == ST_FAULT);
    assign duty_now = duty;

endmodule

// File: rtl/pwm_motor_array.sv
// Multi-channel PWM motor driver: one shared tick prescaler and period counter
// feeding N_CH independent channel controllers.
module pwm_motor_array
    import pwm_motor_array_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int DUTY_W    = DEF_DUTY_W,
    parameter int PRESC     = DEF_PRESC,
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int FILT      = DEF_FILT,
    parameter int HOLD      = DEF_HOLD
) (
    input  logic                     RAW_clk,
    input  logic                     RAW_reset,
    input  logic [N_CH-1:0]          enable,
    input  logic [N_CH-1:0]          dir,
    input  logic [N_CH*DUTY_W-1:0]   duty_tgt,
    input  logic [N_CH-1:0]          sns,
    output logic [N_CH-1:0]          pwm,
    output logic [N_CH-1:0]          fwd,
    output logic [N_CH-1:0]          bwd,
    output logic [N_CH-1:0]          fault,
    output logic [N_CH*DUTY_W-1:0]   duty_now
);

    localparam int PW = $clog2(PRESC);

    logic [PW-1:0]     presc;
    logic [DUTY_W-1:0] cnt;
    logic              tick, period_end;

    assign tick       = (presc == PW'(PRESC - 1));
    assign period_end = tick && (cnt == '1);

    always_ff @(posedge RAW_clk or posedge RAW_reset) begin
        if (RAW_reset) begin
            presc <= '0;
            cnt   <= '0;
        end else if (tick) begin
            presc <= '0;
            cnt   <= cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_motor_channel #(
            .DUTY_W    (DUTY_W),
            .RAMP_STEP (RAMP_STEP),
            .FILT      (FILT),
            .HOLD      (HOLD)
        ) u_ch (
            .clk        (RAW_clk),
            .rst        (RAW_reset),
            .period_end (period_end),
            .cnt        (cnt),
            .enable     (enable[k]),
            .dir        (dir[k]),
            .duty_tgt   (duty_tgt[k*DUTY_W +: DUTY_W]),
            .sns        (sns[k]),
            .pwm        (pwm[k]),
            .fwd        (fwd[k]),
            .bwd        (bwd[k]),
            .fault      (fault[k]),
            .duty_now   (duty_now[k*DUTY_W +: DUTY_W])
        );
    end

endmodule

// File: tb/tb_pwm_motor_array.sv
// Directed bench for pwm_motor_array: ramp, reversal dead period, fault
// lockout, sense glitch rejection and reset during a fault.
module tb_pwm_motor_array;

    localparam int N = 2;
    localparam int W = 4;

    logic           RAW_clk = 1'b0;
    logic           RAW_reset;
    logic [N-1:0]   enable, dir, sns;
    logic [N*W-1:0] duty_tgt;
    logic [N-1:0]   pwm, fwd, bwd, fault;
    logic [N*W-1:0] duty_now;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    pwm_motor_array #(
        .N_CH(N), .DUTY_W(W), .PRESC(2), .RAMP_STEP(2), .FILT(3), .HOLD(2)
    ) dut (
        .RAW_clk   (RAW_clk),
        .RAW_reset (RAW_reset),
        .enable    (enable),
        .dir       (dir),
        .duty_tgt  (duty_tgt),
        .sns       (sns),
        .pwm       (pwm),
        .fwd       (fwd),
        .bwd       (bwd),
        .fault     (fault),
        .duty_now  (duty_now)
    );

    always #5 RAW_clk = ~RAW_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge RAW_clk);
    endtask

    // Wait for the next change of duty_now[ch] and compare it with the scoreboard head.
    task automatic wait_duty(input int ch, input int budget, input string tag, output int clks);
        logic [W-1:0] prev, cur, exp;
        prev = duty_now[ch*W +: W];
        cur  = prev;
        clks = 0;
        do begin
            @(negedge RAW_clk);
            clks++;
            cur = duty_now[ch*W +: W];
        end while (cur == prev && clks < budget);
        check({tag, "_moved"}, 32'(cur != prev), 32'd1);
        exp = exp_q.pop_front();
        check(tag, 32'(cur), 32'(exp));
    endtask

    initial begin
        int n, hi, leak;
        RAW_reset = 1'b1;
        enable    = '0;
        dir       = '0;
        sns       = '0;
        duty_tgt  = '0;
        cycles(3);
        check("rst_pwm",   32'(pwm),      32'd0);
        check("rst_fwd",   32'(fwd),      32'd0);
        check("rst_bwd",   32'(bwd),      32'd0);
        check("rst_fault", 32'(fault),    32'd0);
        check("rst_duty",  32'(duty_now), 32'd0);
        RAW_reset = 1'b0;
        cycles(2);
        check("idle_fwd", 32'(fwd), 32'd0);

        // Ramp channel 0 forward to 7
        enable[0] = 1'b1; dir[0] = 1'b1; duty_tgt[3:0] = 4'd7;
        exp_q.push_back(4'd2); exp_q.push_back(4'd4);
        exp_q.push_back(4'd6); exp_q.push_back(4'd7);
        wait_duty(0, 40, "ramp_s1", n);
        wait_duty(0, 40, "ramp_s2", n);
        check("ramp_period", 32'(n), 32'd32);
        wait_duty(0, 40, "ramp_s3", n);
        wait_duty(0, 40, "ramp_s4", n);
        check("ramp_fwd", 32'(fwd[0]), 32'd1);
        check("ramp_bwd", 32'(bwd[0]), 32'd0);
        hi = 0;
        repeat (32) begin
            @(negedge RAW_clk);
            if (pwm[0]) hi++;
        end
        check("pwm_hi_clocks", 32'(hi), 32'd14);

        // Reversal: drain to 0, one dead period, then backward ramp
        dir[0] = 1'b0;
        exp_q.push_back(4'd5); exp_q.push_back(4'd3);
        exp_q.push_back(4'd1); exp_q.push_back(4'd0);
        wait_duty(0, 40, "drain_s1", n);
        check("drain_fwd_held", 32'(fwd[0]), 32'd1);
        wait_duty(0, 40, "drain_s2", n);
        wait_duty(0, 40, "drain_s3", n);
        wait_duty(0, 40, "drain_s4", n);
        n = 0; leak = 0;
        while (!bwd[0] && n < 80) begin
            if (fwd[0] || pwm[0]) leak++;
            @(negedge RAW_clk);
            n++;
        end
        check("dead_len",   32'(n),      32'd32);
        check("dead_quiet", 32'(leak),   32'd0);
        check("rev_bwd",    32'(bwd[0]), 32'd1);
        check("rev_fwd",    32'(fwd[0]), 32'd0);
        exp_q.push_back(4'd2); exp_q.push_back(4'd4);
        exp_q.push_back(4'd6); exp_q.push_back(4'd7);
        wait_duty(0, 40, "rev_s1", n);
        wait_duty(0, 40, "rev_s2", n);
        wait_duty(0, 40, "rev_s3", n);
        wait_duty(0, 40, "rev_s4", n);

        // Fault on channel 1 while running
        enable[1] = 1'b1; dir[1] = 1'b1; duty_tgt[7:4] = 4'd9;
        exp_q.push_back(4'd2);
        wait_duty(1, 40, "ch1_start", n);
        sns[1] = 1'b1;
        cycles(3);
        sns[1] = 1'b0;
        n = 0;
        while (!fault[1] && n < 12) begin
            @(negedge RAW_clk);
            n++;
        end
        check("fault1_set", 32'(fault[1]), 32'd1);
        check("fault1_fwd", 32'(fwd[1]),   32'd0);
        check("fault1_bwd", 32'(bwd[1]),   32'd0);
        @(negedge RAW_clk);
        check("fault1_pwm",  32'(pwm[1]),        32'd0);
        check("fault1_duty", 32'(duty_now[7:4]), 32'd0);
        check("ch0_duty_iso",  32'(duty_now[3:0]), 32'd7);
        check("ch0_fault_iso", 32'(fault[0]),      32'd0);
        check("ch0_bwd_iso",   32'(bwd[0]),        32'd1);
        n = 0;
        while (fault[1] && n < 150) begin
            @(negedge RAW_clk);
            n++;
        end
        check("fault1_clear", 32'(fault[1]), 32'd0);
        check("hold_window",  32'(n > 30 && n <= 66), 32'd1);
        check("fault1_restart_zero", 32'(duty_now[7:4]), 32'd0);
        exp_q.push_back(4'd2);
        wait_duty(1, 40, "ch1_restart", n);

        // Glitchy sense on channel 0 never reaches three consecutive samples
        sns[0] = 1'b1; cycles(2);
        sns[0] = 1'b0; cycles(1);
        sns[0] = 1'b1; cycles(2);
        sns[0] = 1'b0; cycles(8);
        check("glitch_fault", 32'(fault[0]),      32'd0);
        check("glitch_duty",  32'(duty_now[3:0]), 32'd7);

        // Reset in the middle of a channel 0 lockout
        sns[0] = 1'b1; cycles(5);
        sns[0] = 1'b0;
        n = 0;
        while (!fault[0] && n < 12) begin
            @(negedge RAW_clk);
            n++;
        end
        check("fault0_set", 32'(fault[0]), 32'd1);
        cycles(10);
        #2 RAW_reset = 1'b1;
        #1;
        check("arst_pwm",   32'(pwm),      32'd0);
        check("arst_fwd",   32'(fwd),      32'd0);
        check("arst_bwd",   32'(bwd),      32'd0);
        check("arst_fault", 32'(fault),    32'd0);
        check("arst_duty",  32'(duty_now), 32'd0);
        @(negedge RAW_clk);
        RAW_reset = 1'b0;
        cycles(2);
        check("post_rst_fault", 32'(fault[0]), 32'd0);
        check("post_rst_fwd",   32'(fwd[0]),   32'd0);
        check("post_rst_bwd",   32'(bwd[0]),   32'd1);
        exp_q.push_back(4'd2);
        wait_duty(0, 40, "post_rst_ramp", n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
